// File: rtl/golden_flit_sel.sv
`default_nettype none
// ============================================================================
// golden_flit_sel : per-input-stage arbiter; golden-tag flits win, else round-robin
// Rev 1.0 : initial release
// ============================================================================
module golden_flit_sel #(
  parameter int NUM_PORT = 4,
  parameter int PKTID_W  = 4,
  parameter int COORD_W  = 4,
  parameter int TAG_W    = PKTID_W + COORD_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [TAG_W-1:0]          counterGolden,
  input  logic [NUM_PORT-1:0]       in_valid,
  input  logic [NUM_PORT*TAG_W-1:0] in_tag,
  input  logic                      out_ready,
  output logic [NUM_PORT-1:0]       grant,
  output logic                      grant_valid,
  output logic [NUM_PORT-1:0]       golden_vec,
  output logic                      epoch_pulse,
  output logic [3:0]                golden_cnt
);

  localparam int                  C_PTR_W   = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int                  C_SUM_W   = C_PTR_W + 1;
  localparam logic [3:0]          C_CNT_MAX = 4'd15;
  localparam logic [NUM_PORT-1:0] C_ONE     = NUM_PORT'(1);

  logic [NUM_PORT-1:0] r_grant;
  logic                r_grant_valid;
  logic [NUM_PORT-1:0] r_golden_vec;
  logic                r_epoch_pulse;
  logic [3:0]          r_golden_cnt;
  logic [C_PTR_W-1:0]  r_rr_ptr;
  logic [TAG_W-1:0]    r_golden_q;

  logic [NUM_PORT-1:0] w_match;
  logic                w_gold_found;
  logic [C_PTR_W-1:0]  w_gold_idx;
  logic                w_rr_found;
  logic [C_PTR_W-1:0]  w_rr_idx;
  logic [C_SUM_W-1:0]  w_rr_sum;
  logic [C_PTR_W-1:0]  w_rr_next;
  logic                w_eval;
  logic                w_accept;
  logic                w_gold_acc;
  logic                w_epoch_chg;

  generate
    for (genvar i = 0; i < NUM_PORT; i++) begin : g_match
      assign w_match[i] = in_valid[i] && (in_tag[i*TAG_W +: TAG_W] == counterGolden);
    end
  endgenerate

  // Descending scan so the lowest matching index is the last one written
  always_comb begin
    w_gold_found = |w_match;
    w_gold_idx   = '0;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      if (w_match[i]) w_gold_idx = C_PTR_W'(i);
    end
  end

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_rr_sum   = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      w_rr_sum = {1'b0, r_rr_ptr} + C_SUM_W'(k);
      if (w_rr_sum >= C_SUM_W'(NUM_PORT)) w_rr_sum = w_rr_sum - C_SUM_W'(NUM_PORT);
      if (!w_rr_found && in_valid[w_rr_sum[C_PTR_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_rr_sum[C_PTR_W-1:0];
      end
    end
  end

  assign w_rr_next   = (w_rr_idx == C_PTR_W'(NUM_PORT - 1)) ? '0 : w_rr_idx + 1'b1;
  assign w_eval      = !r_grant_valid || out_ready;
  assign w_accept    = r_grant_valid && out_ready;
  assign w_gold_acc  = w_accept && (|(r_grant & r_golden_vec));
  assign w_epoch_chg = (counterGolden != r_golden_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_golden_vec  <= '0;
      r_epoch_pulse <= 1'b0;
      r_golden_cnt  <= '0;
      r_rr_ptr      <= '0;
      r_golden_q    <= '0;
    end else begin
      r_golden_q    <= counterGolden;
      r_epoch_pulse <= w_epoch_chg;

      // A new epoch restarts the count even if a golden grant is accepted now
      if (w_epoch_chg) begin
        r_golden_cnt <= '0;
      end else if (w_gold_acc && (r_golden_cnt != C_CNT_MAX)) begin
        r_golden_cnt <= r_golden_cnt + 4'd1;
      end

      if (w_eval) begin
        r_golden_vec <= w_match;
        if (w_gold_found) begin
          r_grant       <= C_ONE << w_gold_idx;
          r_grant_valid <= 1'b1;
        end else if (w_rr_found) begin
          r_grant       <= C_ONE << w_rr_idx;
          r_grant_valid <= 1'b1;
          r_rr_ptr      <= w_rr_next;
        end else begin
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
        end
      end
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign golden_vec  = r_golden_vec;
  assign epoch_pulse = r_epoch_pulse;
  assign golden_cnt  = r_golden_cnt;

endmodule
`default_nettype wire

// File: tb/tb_golden_flit_sel.sv
`default_nettype none
// ============================================================================
// tb_golden_flit_sel : directed vector table plus stall/saturation/reset sequences
// Rev 1.0 : initial release
// ============================================================================
module tb_golden_flit_sel;

  logic        clk;
  logic        reset;
  logic [7:0]  counterGolden;
  logic [3:0]  in_valid;
  logic [31:0] in_tag;
  logic        out_ready;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [3:0]  golden_vec;
  logic        epoch_pulse;
  logic [3:0]  golden_cnt;

  int n_vec;
  int n_err;

  golden_flit_sel #(
    .NUM_PORT (4),
    .PKTID_W  (4),
    .COORD_W  (4),
    .TAG_W    (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .counterGolden (counterGolden),
    .in_valid      (in_valid),
    .in_tag        (in_tag),
    .out_ready     (out_ready),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .golden_vec    (golden_vec),
    .epoch_pulse   (epoch_pulse),
    .golden_cnt    (golden_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] tags;
    logic [7:0]  gold;
    logic        ready;
    logic [3:0]  e_grant;
    logic        e_gv;
    logic [3:0]  e_gvec;
    logic        e_pulse;
    logic [3:0]  e_cnt;
  } vec_t;

  localparam logic [31:0] T_G2  = 32'h11_25_12_13;  // only port 2 carries 0x25
  localparam logic [31:0] T_NO  = 32'h11_21_12_13;
  localparam logic [31:0] T_G13 = 32'h25_14_25_13;  // ports 1 and 3 carry 0x25
  localparam logic [31:0] T_P0  = 32'h00_00_00_28;
  localparam logic [31:0] T_S   = 32'h33_32_31_30;

  vec_t tbl [21];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic egv,
                       input logic [3:0] egvec, input logic ep, input logic [3:0] ec);
    n_vec++;
    if (grant !== eg || grant_valid !== egv || golden_vec !== egvec ||
        epoch_pulse !== ep || golden_cnt !== ec) begin
      n_err++;
      $display("FAIL %s: got grant=%b gv=%b gvec=%b pulse=%b cnt=%0d, expected grant=%b gv=%b gvec=%b pulse=%b cnt=%0d",
               name, grant, grant_valid, golden_vec, epoch_pulse, golden_cnt,
               eg, egv, egvec, ep, ec);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] t, input logic [7:0] g, input logic r);
    in_valid      = v;
    in_tag        = t;
    counterGolden = g;
    out_ready     = r;
  endtask

  initial begin
    logic [3:0] exp_cnt;
    n_vec = 0;
    n_err = 0;

    //           valid  tags    gold   rdy   grant  gv    gvec   pulse  cnt
    tbl[0]  = '{4'h0, 32'h0, 8'h00, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'd0};
    tbl[1]  = '{4'h0, 32'h0, 8'h25, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 4'd0};
    tbl[2]  = '{4'hF, T_G2,  8'h25, 1'b1, 4'h4, 1'b1, 4'h4, 1'b0, 4'd0};
    tbl[3]  = '{4'hF, T_G2,  8'h25, 1'b1, 4'h4, 1'b1, 4'h4, 1'b0, 4'd1};
    tbl[4]  = '{4'hF, T_NO,  8'h25, 1'b1, 4'h1, 1'b1, 4'h0, 1'b0, 4'd2};
    tbl[5]  = '{4'hF, T_NO,  8'h25, 1'b1, 4'h2, 1'b1, 4'h0, 1'b0, 4'd2};
    tbl[6]  = '{4'hF, T_NO,  8'h25, 1'b1, 4'h4, 1'b1, 4'h0, 1'b0, 4'd2};
    tbl[7]  = '{4'hF, T_NO,  8'h25, 1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 4'd2};
    tbl[8]  = '{4'hF, T_NO,  8'h25, 1'b1, 4'h1, 1'b1, 4'h0, 1'b0, 4'd2};
    tbl[9]  = '{4'hA, T_NO,  8'h25, 1'b1, 4'h2, 1'b1, 4'h0, 1'b0, 4'd2};
    tbl[10] = '{4'hA, T_NO,  8'h25, 1'b1, 4'h8, 1'b1, 4'h0, 1'b0, 4'd2};
    tbl[11] = '{4'h0, T_NO,  8'h25, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'd2};
    tbl[12] = '{4'hF, T_G13, 8'h25, 1'b1, 4'h2, 1'b1, 4'hA, 1'b0, 4'd2};
    tbl[13] = '{4'hF, T_G13, 8'h25, 1'b1, 4'h2, 1'b1, 4'hA, 1'b0, 4'd3};
    tbl[14] = '{4'hF, T_G13, 8'h26, 1'b1, 4'h1, 1'b1, 4'h0, 1'b1, 4'd0};
    tbl[15] = '{4'hF, T_G13, 8'h26, 1'b1, 4'h2, 1'b1, 4'h0, 1'b0, 4'd0};
    tbl[16] = '{4'hF, T_G13, 8'h27, 1'b1, 4'h4, 1'b1, 4'h0, 1'b1, 4'd0};
    tbl[17] = '{4'hF, T_G13, 8'h28, 1'b1, 4'h8, 1'b1, 4'h0, 1'b1, 4'd0};
    tbl[18] = '{4'h1, T_P0,  8'h28, 1'b1, 4'h1, 1'b1, 4'h1, 1'b0, 4'd0};
    tbl[19] = '{4'h0, T_P0,  8'h28, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'd1};
    tbl[20] = '{4'h0, T_P0,  8'h28, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 4'd1};

    // Reset with random inputs on the pins
    reset = 1'b1;
    drive(4'($urandom), $urandom, 8'($urandom), 1'($urandom));
    tick;
    drive(4'($urandom), $urandom, 8'($urandom), 1'($urandom));
    tick;
    check("reset", 4'h0, 1'b0, 4'h0, 1'b0, 4'd0);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].valid, tbl[i].tags, tbl[i].gold, tbl[i].ready);
      tick;
      check($sformatf("vec%0d", i), tbl[i].e_grant, tbl[i].e_gv, tbl[i].e_gvec,
            tbl[i].e_pulse, tbl[i].e_cnt);
    end

    // Stall: grant 0010 held while tags change (even to all-golden)
    drive(4'hF, T_S, 8'h28, 1'b1);
    tick;
    check("stall_setup0", 4'h1, 1'b1, 4'h0, 1'b0, 4'd1);
    tick;
    check("stall_setup1", 4'h2, 1'b1, 4'h0, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      drive(4'hF, (i == 0) ? 32'h28_28_28_28 : T_P0 + 32'(i), 8'h28, 1'b0);
      tick;
      check($sformatf("stall_hold%0d", i), 4'h2, 1'b1, 4'h0, 1'b0, 4'd1);
    end
    drive(4'hF, T_S, 8'h28, 1'b1);
    tick;
    check("stall_release", 4'h4, 1'b1, 4'h0, 1'b0, 4'd1);

    // Saturation: a steady golden grant accepted every cycle in one epoch
    drive(4'h1, T_P0, 8'h28, 1'b1);
    tick;
    check("sat_first", 4'h1, 1'b1, 4'h1, 1'b0, 4'd1);
    exp_cnt = 4'd1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
      check($sformatf("sat%0d", i), 4'h1, 1'b1, 4'h1, 1'b0, exp_cnt);
    end

    // Reset mid-operation drops the grant and re-arms epoch detection
    reset = 1'b1;
    tick;
    check("midreset", 4'h0, 1'b0, 4'h0, 1'b0, 4'd0);
    reset = 1'b0;
    drive(4'h0, T_P0, 8'h28, 1'b1);
    tick;
    check("post_reset_epoch", 4'h0, 1'b0, 4'h0, 1'b1, 4'd0);
    tick;
    check("post_reset_quiet", 4'h0, 1'b0, 4'h0, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
